// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data memory port arbiter.
// Data and address widths of the memory port are fixed here.
package dmem_arbiter_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DM_ADDRESS = 9;
    localparam int unsigned F3_W       = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_CORE,
        BUSY_EXT
    } arb_state_e;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [DM_ADDRESS-1:0] addr;
        logic [DATA_W-1:0]     wdata;
        logic [F3_W-1:0]       funct3;
    } mem_req_t;

    // Ext master always moves whole words.
    localparam logic [F3_W-1:0] EXT_FUNCT3 = 3'b010;

endpackage

// File: rtl/dmem_arbiter_arb_pick.sv
// Grant choice between the MEM stage and the external master.
// Core wins unless ext has waited long enough to force its turn.
module arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic i_core_req,
    input  logic i_ext_req,
    input  logic i_starve_sat,
    output logic o_grant_core,
    output logic o_grant_ext
);

    logic w_ext_wins;

    assign w_ext_wins   = i_ext_req & (~i_core_req | i_starve_sat);
    assign o_grant_ext  = w_ext_wins;
    assign o_grant_core = i_core_req & ~w_ext_wins;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory port between the pipeline MEM stage and an external master,
// sequencing multi-cycle accesses and stalling the pipeline while the port is busy.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [F3_W-1:0]       core_funct3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [DM_ADDRESS-1:0] ext_addr,
    input  logic [DATA_W-1:0]     ext_wdata,
    output logic                  ext_done,
    output logic [DATA_W-1:0]     ext_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [F3_W-1:0]       mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [STARVE_W-1:0] r_starve;
    logic [STARVE_W-1:0] w_starve_nxt;
    mem_req_t            r_req;
    mem_req_t            w_req_nxt;
    mem_req_t            w_core_fields;
    mem_req_t            w_ext_fields;
    mem_req_t            w_mem;

    logic w_core_req;
    logic w_starve_sat;
    logic w_pick_core;
    logic w_pick_ext;
    logic w_grant_ext;
    logic w_core_done;
    logic w_ext_done;
    logic w_live;

    assign w_core_req   = core_rd | core_wr;
    assign w_starve_sat = (r_starve == STARVE_W'(STARVE_MAX));
    assign w_live       = ~reset;

    // Request payloads as they would be presented to the memory.
    always_comb begin
        w_core_fields.rd     = core_rd;
        w_core_fields.wr     = core_wr;
        w_core_fields.addr   = core_addr;
        w_core_fields.wdata  = core_wdata;
        w_core_fields.funct3 = core_funct3;
        w_ext_fields.rd      = ~ext_we;
        w_ext_fields.wr      = ext_we;
        w_ext_fields.addr    = ext_addr;
        w_ext_fields.wdata   = ext_wdata;
        w_ext_fields.funct3  = EXT_FUNCT3;
    end

    arb_pick u_pick (
        .i_core_req   (w_core_req),
        .i_ext_req    (ext_req),
        .i_starve_sat (w_starve_sat),
        .o_grant_core (w_pick_core),
        .o_grant_ext  (w_pick_ext)
    );

    // Next state, port drive and completion flags.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_mem       = '0;
        w_grant_ext = 1'b0;
        w_core_done = 1'b0;
        w_ext_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_ext) begin
                    w_mem       = w_ext_fields;
                    w_req_nxt   = w_ext_fields;
                    w_grant_ext = 1'b1;
                    if (MEM_LAT <= 1) begin
                        w_ext_done = 1'b1;
                    end else begin
                        w_state_nxt = BUSY_EXT;
                        w_cnt_nxt   = CNT_W'(MEM_LAT - 1);
                    end
                end else if (w_pick_core) begin
                    w_mem     = w_core_fields;
                    w_req_nxt = w_core_fields;
                    if (MEM_LAT <= 1) begin
                        w_core_done = 1'b1;
                    end else begin
                        w_state_nxt = BUSY_CORE;
                        w_cnt_nxt   = CNT_W'(MEM_LAT - 1);
                    end
                end
            end
            BUSY_CORE: begin
                w_mem     = r_req;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_core_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            BUSY_EXT: begin
                w_mem     = r_req;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_ext_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Ext waiting time; not counted while ext itself owns the port.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_grant_ext) begin
            w_starve_nxt = '0;
        end else if (ext_req && (r_state != BUSY_EXT) && !w_starve_sat) begin
            w_starve_nxt = r_starve + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_starve <= '0;
            r_req    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_starve <= w_starve_nxt;
            r_req    <= w_req_nxt;
        end
    end

    // Reset forces every output low at once, even mid-access.
    assign mem_rd     = w_live & w_mem.rd;
    assign mem_wr     = w_live & w_mem.wr;
    assign mem_addr   = w_live ? w_mem.addr : '0;
    assign mem_wdata  = w_live ? w_mem.wdata : '0;
    assign mem_funct3 = w_live ? w_mem.funct3 : '0;
    assign core_stall = w_live & w_core_req & ~w_core_done;
    assign core_rdata = (w_live & w_core_done) ? mem_rdata : '0;
    assign ext_done   = w_live & w_ext_done;
    assign ext_rdata  = (w_live & w_ext_done) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four instances with MEM_LAT 1..4, each checked every cycle
// against a transaction-level model of the port, plus directed scenarios.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int NDUT = 4;
    localparam int SMAX = 4;
    localparam int AW   = DM_ADDRESS;
    localparam int DW   = DATA_W;

    logic clk = 1'b0;
    logic reset;

    logic          core_rd     [NDUT];
    logic          core_wr     [NDUT];
    logic [AW-1:0] core_addr   [NDUT];
    logic [DW-1:0] core_wdata  [NDUT];
    logic [2:0]    core_funct3 [NDUT];
    logic [DW-1:0] core_rdata  [NDUT];
    logic          core_stall  [NDUT];
    logic          ext_req     [NDUT];
    logic          ext_we      [NDUT];
    logic [AW-1:0] ext_addr    [NDUT];
    logic [DW-1:0] ext_wdata   [NDUT];
    logic          ext_done    [NDUT];
    logic [DW-1:0] ext_rdata   [NDUT];
    logic          mem_rd      [NDUT];
    logic          mem_wr      [NDUT];
    logic [AW-1:0] mem_addr    [NDUT];
    logic [DW-1:0] mem_wdata   [NDUT];
    logic [2:0]    mem_funct3  [NDUT];
    logic [DW-1:0] mem_rdata   [NDUT];

    always #5 clk = ~clk;

    // Memory contents as a fixed function of address.
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return {8'hA5 ^ a[7:0], 7'd0, a, 8'(a * 9'd3)};
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_arbiter #(.MEM_LAT(g + 1), .STARVE_MAX(SMAX)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .core_rd     (core_rd[g]),
            .core_wr     (core_wr[g]),
            .core_addr   (core_addr[g]),
            .core_wdata  (core_wdata[g]),
            .core_funct3 (core_funct3[g]),
            .core_rdata  (core_rdata[g]),
            .core_stall  (core_stall[g]),
            .ext_req     (ext_req[g]),
            .ext_we      (ext_we[g]),
            .ext_addr    (ext_addr[g]),
            .ext_wdata   (ext_wdata[g]),
            .ext_done    (ext_done[g]),
            .ext_rdata   (ext_rdata[g]),
            .mem_rd      (mem_rd[g]),
            .mem_wr      (mem_wr[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_funct3  (mem_funct3[g]),
            .mem_rdata   (mem_rdata[g])
        );
        assign mem_rdata[g] = rom(mem_addr[g]);
    end

    int n_chk = 0;
    int n_err = 0;

    // Model: who owns the port (0 none, 1 core, 2 ext), cycles left, latched access, ext wait.
    int       m_who    [NDUT];
    int       m_left   [NDUT];
    int       m_starve [NDUT];
    mem_req_t m_fld    [NDUT];
    int       p_who    [NDUT];
    int       p_left   [NDUT];
    int       p_starve [NDUT];
    mem_req_t p_fld    [NDUT];

    logic          s_stall      [NDUT];
    logic          s_ext_done   [NDUT];
    logic          s_mem_rd     [NDUT];
    logic          s_mem_wr     [NDUT];
    logic [DW-1:0] s_core_rdata [NDUT];
    logic [DW-1:0] s_ext_rdata  [NDUT];

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d t=%0t: observed=%0h expected=%0h", tag, k, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_who[k]      = 0;
            m_left[k]     = 0;
            m_starve[k]   = 0;
            m_fld[k]      = '0;
            s_stall[k]    = 1'b0;
            s_ext_done[k] = 1'b0;
        end
    endtask

    task automatic clear_in(input int k);
        core_rd[k]     = 1'b0;
        core_wr[k]     = 1'b0;
        core_addr[k]   = '0;
        core_wdata[k]  = '0;
        core_funct3[k] = '0;
        ext_req[k]     = 1'b0;
        ext_we[k]      = 1'b0;
        ext_addr[k]    = '0;
        ext_wdata[k]   = '0;
    endtask

    task automatic eval_chk(input int k);
        int       serve;
        int       left_now;
        mem_req_t f;
        logic     creq;
        logic     fin;
        logic     g_ext;
        logic     core_fin;
        logic     ext_fin;
        f        = '0;
        serve    = 0;
        left_now = 0;
        creq     = core_rd[k] | core_wr[k];
        if (m_who[k] == 0) begin
            left_now = k + 1;
            if (ext_req[k] && (!creq || m_starve[k] == SMAX)) begin
                serve    = 2;
                f.rd     = !ext_we[k];
                f.wr     = ext_we[k];
                f.addr   = ext_addr[k];
                f.wdata  = ext_wdata[k];
                f.funct3 = 3'b010;
            end else if (creq) begin
                serve    = 1;
                f.rd     = core_rd[k];
                f.wr     = core_wr[k];
                f.addr   = core_addr[k];
                f.wdata  = core_wdata[k];
                f.funct3 = core_funct3[k];
            end
        end else begin
            serve    = m_who[k];
            f        = m_fld[k];
            left_now = m_left[k];
        end
        g_ext    = (m_who[k] == 0) && (serve == 2);
        fin      = (serve != 0) && (left_now == 1);
        core_fin = fin && (serve == 1);
        ext_fin  = fin && (serve == 2);

        chk("mem_rd", k, 64'(mem_rd[k]), 64'(f.rd));
        chk("mem_wr", k, 64'(mem_wr[k]), 64'(f.wr));
        chk("mem_addr", k, 64'(mem_addr[k]), 64'(f.addr));
        chk("mem_wdata", k, 64'(mem_wdata[k]), 64'(f.wdata));
        chk("mem_funct3", k, 64'(mem_funct3[k]), 64'(f.funct3));
        chk("core_stall", k, 64'(core_stall[k]), 64'(creq && !core_fin));
        chk("ext_done", k, 64'(ext_done[k]), 64'(ext_fin));
        chk("core_rdata", k, 64'(core_rdata[k]), core_fin ? 64'(rom(f.addr)) : 64'd0);
        chk("ext_rdata", k, 64'(ext_rdata[k]), ext_fin ? 64'(rom(f.addr)) : 64'd0);

        s_stall[k]      = core_stall[k];
        s_ext_done[k]   = ext_done[k];
        s_mem_rd[k]     = mem_rd[k];
        s_mem_wr[k]     = mem_wr[k];
        s_core_rdata[k] = core_rdata[k];
        s_ext_rdata[k]  = ext_rdata[k];

        p_who[k]  = 0;
        p_left[k] = 0;
        p_fld[k]  = '0;
        if (serve != 0 && !fin) begin
            p_who[k]  = serve;
            p_left[k] = left_now - 1;
            p_fld[k]  = f;
        end
        if (g_ext) p_starve[k] = 0;
        else if (ext_req[k] && serve != 2) p_starve[k] = (m_starve[k] < SMAX) ? m_starve[k] + 1 : SMAX;
        else p_starve[k] = m_starve[k];
    endtask

    // One clock: check all instances mid-cycle, advance model at the edge.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) eval_chk(k);
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) begin
            m_who[k]    = p_who[k];
            m_left[k]   = p_left[k];
            m_fld[k]    = p_fld[k];
            m_starve[k] = p_starve[k];
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) clear_in(k);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_mem_rd", k, 64'(mem_rd[k]), 64'd0);
            chk("rst_mem_wr", k, 64'(mem_wr[k]), 64'd0);
            chk("rst_stall", k, 64'(core_stall[k]), 64'd0);
            chk("rst_ext_done", k, 64'(ext_done[k]), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drive_rand(input int k);
        int r;
        if (!((core_rd[k] | core_wr[k]) && s_stall[k])) begin
            r              = $urandom_range(0, 3);
            core_rd[k]     = (r == 1);
            core_wr[k]     = (r == 2);
            core_addr[k]   = AW'($urandom);
            core_wdata[k]  = $urandom;
            core_funct3[k] = 3'($urandom_range(0, 7));
        end
        if (!(ext_req[k] && !s_ext_done[k])) begin
            ext_req[k]   = ($urandom_range(0, 2) == 0);
            ext_we[k]    = 1'($urandom_range(0, 1));
            ext_addr[k]  = AW'($urandom);
            ext_wdata[k] = $urandom;
        end
    endtask

    initial begin
        logic [4:0]    vec_stall;
        logic [4:0]    vec_done;
        int            cnt_a;
        int            cnt_b;
        int            c_ext;
        int            c_core;
        logic [DW-1:0] cap;
        logic [DW-1:0] x5;
        logic [DW-1:0] x6;
        logic [DW-1:0] exp6;
        logic          got;

        // Reset with live requests applied: everything must stay quiet.
        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) clear_in(k);
        model_reset();
        core_rd[0] = 1'b1;
        core_addr[0] = 9'h10;
        ext_req[3] = 1'b1;
        ext_we[3] = 1'b1;
        #12;
        chk("reset_mem_rd", 0, 64'(mem_rd[0]), 64'd0);
        chk("reset_stall", 0, 64'(core_stall[0]), 64'd0);
        chk("reset_mem_wr", 3, 64'(mem_wr[3]), 64'd0);
        chk("reset_ext_done", 3, 64'(ext_done[3]), 64'd0);
        for (int k = 0; k < NDUT; k++) clear_in(k);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        tick();

        // Single-cycle core load: no stall, data same cycle.
        core_rd[0] = 1'b1;
        core_addr[0] = 9'h10;
        core_funct3[0] = 3'b010;
        tick();
        chk("t1_mem_rd", 0, 64'(s_mem_rd[0]), 64'd1);
        chk("t1_stall", 0, 64'(s_stall[0]), 64'd0);
        chk("t1_rdata", 0, 64'(s_core_rdata[0]), 64'(rom(9'h10)));
        clear_in(0);
        tick();

        // Three-cycle core store.
        core_wr[2] = 1'b1;
        core_addr[2] = 9'h20;
        core_wdata[2] = 32'hDEADBEEF;
        core_funct3[2] = 3'b010;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt_a += int'(s_stall[2]);
            cnt_b += int'(s_mem_wr[2]);
            if (!s_stall[2]) clear_in(2);
        end
        chk("t2_stall_cycles", 2, 64'(cnt_a), 64'd2);
        chk("t2_wr_cycles", 2, 64'(cnt_b), 64'd3);

        // Persistent contention: ext forced through on the fifth cycle.
        core_rd[0] = 1'b1;
        core_addr[0] = 9'h11;
        ext_req[0] = 1'b1;
        ext_addr[0] = 9'h33;
        vec_stall = '0;
        vec_done = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            vec_stall[c] = s_stall[0];
            vec_done[c] = s_ext_done[0];
        end
        chk("t3_stall_vec", 0, 64'(vec_stall), 64'b10000);
        chk("t3_done_vec", 0, 64'(vec_done), 64'b10000);
        chk("t3_starve", 0, 64'(g_dut[0].u_dut.r_starve), 64'd0);
        clear_in(0);
        tick();

        // Ext read in flight, core load arrives one cycle later.
        ext_req[1] = 1'b1;
        ext_addr[1] = 9'h40;
        c_ext = -1;
        c_core = -1;
        cnt_a = 0;
        cap = '0;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin
                core_rd[1] = 1'b1;
                core_addr[1] = 9'h44;
            end
            tick();
            cnt_a += int'(s_stall[1]);
            if (s_ext_done[1]) begin
                c_ext = c;
                cap = s_ext_rdata[1];
                ext_req[1] = 1'b0;
            end
            if (core_rd[1] && !s_stall[1]) begin
                c_core = c;
                core_rd[1] = 1'b0;
            end
        end
        chk("t4_ext_done_cyc", 1, 64'(c_ext), 64'd1);
        chk("t4_ext_rdata", 1, 64'(cap), 64'(rom(9'h40)));
        chk("t4_core_done_cyc", 1, 64'(c_core), 64'd3);
        chk("t4_stall_cycles", 1, 64'(cnt_a), 64'd2);

        // Reset lands in the second busy cycle of a four-cycle ext write.
        ext_req[3] = 1'b1;
        ext_we[3] = 1'b1;
        ext_addr[3] = 9'h55;
        ext_wdata[3] = 32'h1234_5678;
        tick();
        tick();
        #2;
        chk("t5_busy_wr", 3, 64'(mem_wr[3]), 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_wr", 3, 64'(mem_wr[3]), 64'd0);
        chk("t5_rst_addr", 3, 64'(mem_addr[3]), 64'd0);
        chk("t5_rst_done", 3, 64'(ext_done[3]), 64'd0);
        clear_in(3);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cnt_a = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            cnt_a += int'(s_ext_done[3]);
        end
        chk("t5_no_done", 3, 64'(cnt_a), 64'd0);

        // Random traffic on every instance with occasional resets.
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < NDUT; k++) drive_rand(k);
            tick();
            if ($urandom_range(0, 199) == 0) do_reset();
        end
        for (int k = 0; k < NDUT; k++) clear_in(k);
        for (int c = 0; c < 6; c++) tick();

        // Load-use pair behind ext traffic: lw x5,0(x0); add x6,x5,x5.
        ext_req[1] = 1'b1;
        ext_addr[1] = 9'h80;
        tick();
        core_rd[1] = 1'b1;
        core_addr[1] = '0;
        core_funct3[1] = 3'b010;
        got = 1'b0;
        x5 = '0;
        for (int c = 0; c < 12; c++) begin
            if (!got) begin
                tick();
                if (s_ext_done[1]) ext_req[1] = 1'b0;
                if (!s_stall[1]) begin
                    x5 = s_core_rdata[1];
                    got = 1'b1;
                    core_rd[1] = 1'b0;
                end
            end
        end
        chk("t6_load_done", 1, 64'(got), 64'd1);
        x6 = x5 + x5;
        exp6 = rom('0) << 1;
        chk("t6_x6", 1, 64'(x6), 64'(exp6));
        clear_in(1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
